// File: rtl/alu_pkg.sv
// Opcode encodings and FSM states for the accumulator ALU.
// Shared by alu_acc_seq, alu_mul_seq and the bench.
package alu_pkg;

  localparam logic [7:0] ALU_CLEAR = 8'd0;
  localparam logic [7:0] ALU_INC   = 8'd1;
  localparam logic [7:0] ALU_DEC   = 8'd2;
  localparam logic [7:0] ALU_ADD   = 8'd3;
  localparam logic [7:0] ALU_SUB   = 8'd4;
  localparam logic [7:0] ALU_MUL2  = 8'd5;
  localparam logic [7:0] ALU_MUL4  = 8'd6;
  localparam logic [7:0] ALU_DIV16 = 8'd7;
  localparam logic [7:0] ALU_LOAD  = 8'd8;
  localparam logic [7:0] ALU_NOP   = 8'd9;
  localparam logic [7:0] ALU_AND   = 8'd10;
  localparam logic [7:0] ALU_OR    = 8'd11;
  localparam logic [7:0] ALU_XOR   = 8'd12;
  localparam logic [7:0] ALU_SHR   = 8'd13;
  localparam logic [7:0] ALU_MUL   = 8'd14;

  typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done/product are combinational on the final step edge.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   A,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mc_q;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mp_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Partial sum for the current step.
  always_comb begin
    sum = acc_q + (mp_q[0] ? mc_q : '0);
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = sum;

  // Load operands on start, then shift-add until the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      acc_q  <= '0;
      mc_q   <= {{WIDTH{1'b0}}, A};
      mp_q   <= B;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= sum;
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with valid/ready handshake and flags.
// Define ALU_MUL_EN to build opcode 14 as an iterative multiply.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       alu_instruction,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] A,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_nx;
  logic             c_q;
  logic             c_nx;
  logic             done_q;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] mask;
  logic [SHW-1:0]   sh;
  logic             accept;
  logic             single;
  logic             mul_done;
  logic [WIDTH-1:0] mul_a;
  logic             mul_c;

  assign accept = op_valid & op_ready;

  // Single-cycle datapath: next A and carry for the decoded op.
  always_comb begin
    a_nx = a_q;
    c_nx = c_q;
    ext  = '0;
    sh   = B[SHW-1:0];
    mask = ~({WIDTH{1'b1}} << sh);
    case (alu_instruction)
      ALU_CLEAR: begin
        a_nx = '0;
        c_nx = 1'b0;
      end
      ALU_INC: begin
        ext  = {1'b0, a_q} + ONE;
        a_nx = ext[WIDTH-1:0];
        c_nx = ext[WIDTH];
      end
      ALU_DEC: begin
        ext  = {1'b0, a_q} - ONE;
        a_nx = ext[WIDTH-1:0];
        c_nx = ext[WIDTH];
      end
      ALU_ADD: begin
        ext  = {1'b0, a_q} + {1'b0, B};
        a_nx = ext[WIDTH-1:0];
        c_nx = ext[WIDTH];
      end
      ALU_SUB: begin
        ext  = {1'b0, a_q} - {1'b0, B};
        a_nx = ext[WIDTH-1:0];
        c_nx = ext[WIDTH];
      end
      ALU_MUL2: begin
        a_nx = {a_q[WIDTH-2:0], 1'b0};
        c_nx = a_q[WIDTH-1];
      end
      ALU_MUL4: begin
        a_nx = {a_q[WIDTH-3:0], 2'b00};
        c_nx = |a_q[WIDTH-1:WIDTH-2];
      end
      ALU_DIV16: begin
        a_nx = {4'b0000, a_q[WIDTH-1:4]};
        c_nx = |a_q[3:0];
      end
      ALU_LOAD: begin
        a_nx = B;
        c_nx = 1'b0;
      end
      ALU_AND: a_nx = a_q & B;
      ALU_OR:  a_nx = a_q | B;
      ALU_XOR: a_nx = a_q ^ B;
      ALU_SHR: begin
        a_nx = a_q >> sh;
        c_nx = |(a_q & mask);
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               mul_go;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_p;
  logic               ready_q;
  state_t             state;

  assign mul_go   = accept && (alu_instruction == ALU_MUL);
  assign single   = accept && !mul_go;
  assign mul_a    = mul_p[WIDTH-1:0];
  assign mul_c    = |mul_p[2*WIDTH-1:WIDTH];
  assign op_ready = ready_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_go),
    .B       (B),
    .A       (a_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  // Hold off new ops while the multiplier iterates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (mul_go && !mul_busy) begin
          state   <= MUL;
          ready_q <= 1'b0;
        end
        MUL: if (mul_done) begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign single   = accept;
  assign mul_done = 1'b0;
  assign mul_a    = '0;
  assign mul_c    = 1'b0;
  assign op_ready = 1'b1;
`endif

  // Accumulator, carry and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= single | mul_done;
      if (single) begin
        a_q <= a_nx;
        c_q <= c_nx;
      end else if (mul_done) begin
        a_q <= mul_a;
        c_q <= mul_c;
      end
    end
  end

  assign A    = a_q;
  assign c    = c_q;
  assign z    = (a_q == '0);
  assign n    = a_q[WIDTH-1];
  assign done = done_q;

endmodule
